mux_select_unit: RTL and testbench
==================================

Name: mux_select_unit

Overview:
- Registered selection block with a 2-way path and a 3-way path on shared N-bit operands x, y and z.
- Delivers one-cycle-latency selected results to downstream datapath stages (e.g. perceptron weight/input routing).
- Flags the undefined 3-way select code.
- Data is treated as raw bits; signedness passes through unchanged.

Parameters:
- N, default 3, data width of x, y, z, out2, out3 (legal N >= 1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and selects are valid this cycle
- x  input  N  operand 0
- y  input  N  operand 1
- z  input  N  operand 2 (3-way path only)
- sel2  input  1  2-way select
- sel3  input  2  3-way select
- out2  output  N  registered 2-way result
- out3  output  N  registered 3-way result
- out_valid  output  1  out2/out3/sel3_err updated by the previous cycle's capture
- sel3_err  output  1  sel3 was 2'b11 at the last capture

Behaviour:
- Reset:
  - rst_n low immediately (asynchronously) forces out2=0, out3=0, out_valid=0, sel3_err=0.
  - Outputs hold these values while rst_n is low.
  - Release is sampled at the next rising clk edge.
- 2-way select: sel2=0 -> x; sel2=1 -> y.
- 3-way select:
  - sel3=00 -> x; 01 -> y; 10 -> z.
  - 11 -> all-zero N-bit value, and the error condition is true.
- Capture: on a rising clk edge with in_valid=1:
  - out2 <= 2-way select
  - out3 <= 3-way select
  - sel3_err <= (sel3==2'b11)
- Hold: on a rising clk edge with in_valid=0, out2, out3 and sel3_err hold their previous values.
- out_valid <= in_valid on every rising edge, giving exactly 1-cycle latency.
  - Back-to-back in_valid produces back-to-back out_valid.
  - There is no backpressure; the consumer must accept out_valid when it is asserted.
- Select changes between edges have no effect on the outputs; only the value present at the edge is captured.
- x/y/z bit patterns are passed exactly: no sign extension, no arithmetic.
- Reset asserted mid-stream: any pending capture is lost, and out_valid is 0 on the first edge after release unless in_valid=1 at that edge.
- All outputs are driven directly from flops; there is no combinational input-to-output path.

Optional Feature:
- MUX_ERR_STICKY_EN defined:
  - sel3_err is sticky: it sets on any capture with sel3==11.
  - It remains 1 until rst_n is asserted, regardless of later captures.
- MUX_ERR_STICKY_EN undefined: sel3_err reflects only the most recent capture, as described in Behaviour.
- Data paths and out_valid are identical in both builds.

Test Plan:
- Reset: pulse rst_n low mid-cycle with out2=3'b010 and out_valid=1 -> out2=0, out3=0, out_valid=0, sel3_err=0 immediately, without waiting for a clock edge.
- 2-way path: N=3, x=3'b101, y=3'b010, in_valid=1; sel2 sequence 1, 0, 1 on successive edges -> out2 = 010, 101, 010, each one cycle after its capture edge; out_valid=1.
- 3-way path: x=101, y=010, z=111; sel3 sequence 00, 01, 10 -> out3 = 101, 010, 111 one cycle later; sel3_err=0 throughout.
- Illegal code: sel3=11 captured -> out3=000 and sel3_err=1; next capture with sel3=00 gives:
  - sel3_err=0 without MUX_ERR_STICKY_EN
  - sel3_err=1 with MUX_ERR_STICKY_EN
- Hold: capture out2=101, then in_valid=0 for 3 cycles while sel2 toggles -> out2 stays 101 and out_valid=0 during the idle cycles.
- Width: N=8, x=8'h80, y=8'h7F, sel2=0 -> out2=8'h80 exactly (no sign extension); sel2=1 -> 8'h7F.

Source files
------------

// File: rtl/mux_select_unit.sv
// Registered 2-way and 3-way operand selector with an undefined-code flag.
// Optional build macro MUX_ERR_STICKY_EN makes sel3_err sticky until reset.
module mux_select_unit #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic [N-1:0] z,
    input  logic         sel2,
    input  logic [1:0]   sel3,
    output logic [N-1:0] out2,
    output logic [N-1:0] out3,
    output logic         out_valid,
    output logic         sel3_err
);

    logic [N-1:0] sel2_val;
    logic [N-1:0] sel3_val;
    logic         sel3_bad;
    logic         sel3_err_next;

    assign sel2_val = sel2 ? y : x;

    always_comb begin
        // NOTE: default first so every path assigns sel3_val and no latch is inferred.
        sel3_val = '0;
        sel3_bad = 1'b0;
        unique case (sel3)
            2'b00:   sel3_val = x;
            2'b01:   sel3_val = y;
            2'b10:   sel3_val = z;
            default: sel3_bad = 1'b1;
        endcase
    end

`ifdef MUX_ERR_STICKY_EN
    assign sel3_err_next = sel3_err | sel3_bad;
`else
    assign sel3_err_next = sel3_bad;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out2      <= '0;
            out3      <= '0;
            out_valid <= 1'b0;
            sel3_err  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            out_valid <= in_valid;
            if (in_valid) begin
                out2     <= sel2_val;
                out3     <= sel3_val;
                sel3_err <= sel3_err_next;
            end
        end
    end

endmodule

// File: tb/tb_mux_select_unit.sv
// Self-checking bench for mux_select_unit: directed table, reset/hold corner
// cases, N=8 width checks and randomized stimulus against a reference model.
module tb_mux_select_unit;

`ifdef MUX_ERR_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] x = '0, y = '0, z = '0;
    logic       sel2 = 1'b0;
    logic [1:0] sel3 = '0;
    logic [2:0] out2, out3;
    logic       out_valid, sel3_err;

    logic       v8 = 1'b0;
    logic [7:0] x8 = '0, y8 = '0, z8 = '0;
    logic       s2_8 = 1'b0;
    logic [1:0] s3_8 = '0;
    logic [7:0] out2_8, out3_8;
    logic       ov_8, err_8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mux_select_unit #(.N(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .x(x), .y(y), .z(z), .sel2(sel2), .sel3(sel3),
        .out2(out2), .out3(out3), .out_valid(out_valid), .sel3_err(sel3_err)
    );

    mux_select_unit #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8),
        .x(x8), .y(y8), .z(z8), .sel2(s2_8), .sel3(s3_8),
        .out2(out2_8), .out3(out3_8), .out_valid(ov_8), .sel3_err(err_8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic s2, input logic [1:0] s3,
                         input logic [2:0] xi, input logic [2:0] yi, input logic [2:0] zi);
        @(negedge clk);
        in_valid = v; sel2 = s2; sel3 = s3; x = xi; y = yi; z = zi;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [2:0] e2, input logic [2:0] e3,
                             input logic ev, input logic ee);
        check({tag, ".out2"}, out2, e2);
        check({tag, ".out3"}, out3, e3);
        check({tag, ".out_valid"}, out_valid, ev);
        check({tag, ".sel3_err"}, sel3_err, ee);
    endtask

    typedef struct {
        logic       v;
        logic       s2;
        logic [1:0] s3;
        logic [2:0] xi, yi, zi;
        logic [2:0] e2, e3;
        logic       ev, ee;
    } vec_t;

    vec_t tbl[8];

    // Reference model state: the last captured selection results.
    logic [2:0] m_out2, m_out3;
    logic       m_valid, m_err;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 1'b1, 2'b00, 3'b101, 3'b010, 3'b111, 3'b010, 3'b101, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 2'b01, 3'b101, 3'b010, 3'b111, 3'b101, 3'b010, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 2'b10, 3'b101, 3'b010, 3'b111, 3'b010, 3'b111, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 2'b11, 3'b101, 3'b010, 3'b111, 3'b101, 3'b000, 1'b1, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 2'b00, 3'b101, 3'b010, 3'b111, 3'b101, 3'b101, 1'b1, STICKY};
        tbl[5] = '{1'b0, 1'b1, 2'b10, 3'b101, 3'b010, 3'b111, 3'b101, 3'b101, 1'b0, STICKY};
        tbl[6] = '{1'b0, 1'b0, 2'b01, 3'b101, 3'b010, 3'b111, 3'b101, 3'b101, 1'b0, STICKY};
        tbl[7] = '{1'b0, 1'b1, 2'b11, 3'b101, 3'b010, 3'b111, 3'b101, 3'b101, 1'b0, STICKY};

        // Reset state while held in reset across edges.
        repeat (2) @(posedge clk);
        #1;
        check_all("reset_hold", 3'b000, 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table: 2-way, 3-way, illegal code, then three idle cycles.
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].v, tbl[i].s2, tbl[i].s3, tbl[i].xi, tbl[i].yi, tbl[i].zi);
            check_all($sformatf("tbl%0d", i), tbl[i].e2, tbl[i].e3, tbl[i].ev, tbl[i].ee);
        end

        // Inputs changed between edges must not reach the outputs.
        drive(1'b1, 1'b1, 2'b10, 3'b101, 3'b010, 3'b111);
        sel2 = 1'b0; sel3 = 2'b11; x = 3'b001; y = 3'b110; z = 3'b011;
        #2;
        check_all("no_comb_path", 3'b010, 3'b111, 1'b1, STICKY);

        // Asynchronous reset mid-cycle with out2=010 and out_valid=1.
        drive(1'b1, 1'b1, 2'b00, 3'b101, 3'b010, 3'b111);
        check("pre_rst.out2", out2, 3'b010);
        check("pre_rst.out_valid", out_valid, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 3'b000, 3'b000, 1'b0, 1'b0);
        // Release with in_valid=0: first edge after release gives out_valid=0.
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_rst_idle", 3'b000, 3'b000, 1'b0, 1'b0);
        // Reset pulse while a capture is pending, released with in_valid=1.
        @(negedge clk);
        in_valid = 1'b1; sel2 = 1'b0; sel3 = 2'b11; x = 3'b110;
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        #1;
        check_all("pending_lost", 3'b000, 3'b000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_all("post_rst_cap", 3'b110, 3'b000, 1'b1, 1'b1);

        // Width: N=8 patterns pass bit-exact with no sign extension.
        @(negedge clk);
        v8 = 1'b1; x8 = 8'h80; y8 = 8'h7F; z8 = 8'hA5; s2_8 = 1'b0; s3_8 = 2'b10;
        @(posedge clk);
        #1;
        check("w8.out2_x", out2_8, 8'h80);
        check("w8.out3_z", out3_8, 8'hA5);
        @(negedge clk);
        s2_8 = 1'b1; s3_8 = 2'b01;
        @(posedge clk);
        #1;
        check("w8.out2_y", out2_8, 8'h7F);
        check("w8.out3_y", out3_8, 8'h7F);
        check("w8.out_valid", ov_8, 1'b1);

        // Randomized stimulus against the reference model, from a fresh reset.
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #2 rst_n = 1'b1;
        m_out2 = '0; m_out3 = '0; m_valid = 1'b0; m_err = 1'b0;
        for (int i = 0; i < 300; i++) begin
            logic       rv, rs2;
            logic [1:0] rs3;
            logic [2:0] rx, ry, rz;
            logic [2:0] opts[4];
            rv  = ($urandom_range(0, 9) < 7);
            rs2 = 1'($urandom);
            rs3 = 2'($urandom);
            rx  = 3'($urandom);
            ry  = 3'($urandom);
            rz  = 3'($urandom);
            opts[0] = rx; opts[1] = ry; opts[2] = rz; opts[3] = 3'b000;
            m_valid = rv;
            if (rv) begin
                m_out2 = rs2 ? ry : rx;
                m_out3 = opts[rs3];
                m_err  = (rs3 == 2'b11) || (STICKY && m_err);
            end
            drive(rv, rs2, rs3, rx, ry, rz);
            check_all($sformatf("rand%0d", i), m_out2, m_out3, m_valid, m_err);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
